// File: rtl/iqe_sched_pkg.sv
// Shared types and constants for the extra-instruction-queue read scheduler.
package iqe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_T0 = 2'd1,
    RUN_T1 = 2'd2,
    DRAIN  = 2'd3
  } iqe_sched_state_t;

  localparam int IQE_DEPTH  = 16;
  localparam int IQE_OCC_W  = 5;

  // Pop count: the smallest of two, the selected thread's occupancy and the free backend slots.
  function automatic logic [2:0] rd_cnt_min(input logic [IQE_OCC_W-1:0] occ,
                                            input logic [1:0]           room);
    logic [2:0] lim;
    lim = (room > 2'd2) ? 3'd2 : {1'b0, room};
    if ({2'b00, lim} > occ) begin
      return occ[2:0];
    end else begin
      return lim;
    end
  endfunction

endpackage

// File: rtl/iqe_occ_cnt.sv
// Per-thread occupancy counter: adds accepted writes, subtracts pops, clears on flush.
module iqe_occ_cnt
  import iqe_sched_pkg::*;
#(
  parameter int DEPTH = IQE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [2:0]           inc,
  input  logic [1:0]           dec,
  output logic [IQE_OCC_W-1:0] occ,
  output logic [IQE_OCC_W-1:0] occ_next
);

  localparam logic [IQE_OCC_W:0]   DEPTH_W   = (IQE_OCC_W+1)'(DEPTH);
  localparam logic [IQE_OCC_W-1:0] DEPTH_OCC = IQE_OCC_W'(DEPTH);

  logic [IQE_OCC_W:0] sum_s;
  logic [IQE_OCC_W:0] diff_s;

  // Next occupancy; a flush wins over any same-cycle write or pop, and the result is held in 0..DEPTH.
  always_comb begin
    sum_s  = {1'b0, occ} + {3'b000, inc};
    diff_s = sum_s - {4'b0000, dec};
    if (clr) begin
      occ_next = {IQE_OCC_W{1'b0}};
    end else if (sum_s < {4'b0000, dec}) begin
      occ_next = {IQE_OCC_W{1'b0}};
    end else if (diff_s > DEPTH_W) begin
      occ_next = DEPTH_OCC;
    end else begin
      occ_next = diff_s[IQE_OCC_W-1:0];
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= {IQE_OCC_W{1'b0}};
    end else begin
      occ <= occ_next;
    end
  end

endmodule

// File: rtl/iqe_read_sched.sv
// Read-side scheduler for the two-thread extra instruction queue: picks the reading
// thread, sizes each pop, round-robins with a fixed quantum and handles flushes.
module iqe_read_sched
  import iqe_sched_pkg::*;
#(
  parameter int QUANTUM = 8,
  parameter int DEPTH   = IQE_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       except,
  input  logic       except_thread,
  input  logic       stall,
  input  logic       wr_en,
  input  logic       wr_thread,
  input  logic [2:0] wr_cnt,
  input  logic [1:0] disp_room,
  input  logic [1:0] thread_en,
  output logic       read_thread,
  output logic [2:0] read_cnt,
  output logic [4:0] occ0,
  output logic [4:0] occ1
);

  localparam int            QW     = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);
  localparam logic [QW-1:0] Q_ZERO = QW'(0);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);

  iqe_sched_state_t     state_r;
  logic                 read_thread_r;
  logic                 last_served_r;
  logic [QW-1:0]        quantum_r;

  logic [IQE_OCC_W-1:0] occ_cur_s;
  logic [IQE_OCC_W-1:0] occ_nx0_s;
  logic [IQE_OCC_W-1:0] occ_nx1_s;
  logic [2:0]           inc0_s;
  logic [2:0]           inc1_s;
  logic [1:0]           dec0_s;
  logic [1:0]           dec1_s;
  logic                 clr0_s;
  logic                 clr1_s;
  logic                 run_s;
  logic                 pop_s;
  logic [1:0]           ready_s;
  logic                 flush_cur_s;
  logic                 yield_s;

  // Pop size for the selected thread; nothing pops outside RUN or for a disabled thread.
  always_comb begin
    occ_cur_s = read_thread_r ? occ1 : occ0;
    run_s     = (state_r == RUN_T0) || (state_r == RUN_T1);
    if (run_s && thread_en[read_thread_r]) begin
      read_cnt = rd_cnt_min(occ_cur_s, disp_room);
    end else begin
      read_cnt = 3'd0;
    end
  end

  // Counter controls: writes always land, pops only when the backend is not stalled.
  always_comb begin
    inc0_s = (wr_en && (wr_thread == 1'b0)) ? wr_cnt : 3'd0;
    inc1_s = (wr_en && (wr_thread == 1'b1)) ? wr_cnt : 3'd0;
    dec0_s = (!stall && (read_thread_r == 1'b0)) ? read_cnt[1:0] : 2'd0;
    dec1_s = (!stall && (read_thread_r == 1'b1)) ? read_cnt[1:0] : 2'd0;
    clr0_s = except && (except_thread == 1'b0);
    clr1_s = except && (except_thread == 1'b1);
  end

  // Readiness looks at next-cycle occupancy so an emptied thread yields without a bubble.
  always_comb begin
    ready_s[0]  = thread_en[0] && (occ_nx0_s != {IQE_OCC_W{1'b0}});
    ready_s[1]  = thread_en[1] && (occ_nx1_s != {IQE_OCC_W{1'b0}});
    pop_s       = !stall && (read_cnt != 3'd0);
    flush_cur_s = except && (except_thread == read_thread_r) && run_s;
    yield_s     = !ready_s[read_thread_r] ||
                  ((quantum_r == Q_LAST) && pop_s && ready_s[~read_thread_r]);
  end

  iqe_occ_cnt #(.DEPTH(DEPTH)) u_occ0 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr0_s),
    .inc      (inc0_s),
    .dec      (dec0_s),
    .occ      (occ0),
    .occ_next (occ_nx0_s)
  );

  iqe_occ_cnt #(.DEPTH(DEPTH)) u_occ1 (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr1_s),
    .inc      (inc1_s),
    .dec      (dec1_s),
    .occ      (occ1),
    .occ_next (occ_nx1_s)
  );

  // Scheduling state machine with quantum counter, tie-break history and selected thread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      read_thread_r <= 1'b0;
      quantum_r     <= Q_ZERO;
      last_served_r <= 1'b1;
    end else if (flush_cur_s) begin
      state_r   <= DRAIN;
      quantum_r <= Q_ZERO;
    end else if (stall) begin
      state_r   <= state_r;
      quantum_r <= quantum_r;
    end else begin
      case (state_r)
        IDLE, DRAIN: begin
          if (ready_s[0] && ready_s[1]) begin
            state_r       <= last_served_r ? RUN_T0 : RUN_T1;
            read_thread_r <= ~last_served_r;
          end else if (ready_s[0]) begin
            state_r       <= RUN_T0;
            read_thread_r <= 1'b0;
          end else if (ready_s[1]) begin
            state_r       <= RUN_T1;
            read_thread_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN_T0, RUN_T1: begin
          if (yield_s) begin
            last_served_r <= read_thread_r;
            quantum_r     <= Q_ZERO;
            if (ready_s[~read_thread_r]) begin
              state_r       <= read_thread_r ? RUN_T0 : RUN_T1;
              read_thread_r <= ~read_thread_r;
            end else begin
              state_r <= IDLE;
            end
          end else if (pop_s) begin
            // Expiry with no ready peer simply starts a fresh quantum on the same thread.
            quantum_r <= (quantum_r == Q_LAST) ? Q_ZERO : (quantum_r + Q_ONE);
          end else begin
            quantum_r <= quantum_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          quantum_r <= Q_ZERO;
        end
      endcase
    end
  end

  assign read_thread = read_thread_r;

endmodule

// File: tb/tb_iqe_read_sched.sv
// Bench for iqe_read_sched: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural scheduler model.
module tb_iqe_read_sched;

  localparam int QUANTUM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       except;
  logic       except_thread;
  logic       stall;
  logic       wr_en;
  logic       wr_thread;
  logic [2:0] wr_cnt;
  logic [1:0] disp_room;
  logic [1:0] thread_en;
  logic       read_thread;
  logic [2:0] read_cnt;
  logic [4:0] occ0;
  logic [4:0] occ1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: occupancies, current thread, whether a thread is actively being served,
  // how many popping cycles it has used, and who was served last.
  int m_occ[2];
  int m_cur;
  bit m_run;
  int m_used;
  int m_last;

  always #5 clk = ~clk;

  iqe_read_sched #(.QUANTUM(QUANTUM)) dut (
    .clk           (clk),
    .rst           (rst),
    .except        (except),
    .except_thread (except_thread),
    .stall         (stall),
    .wr_en         (wr_en),
    .wr_thread     (wr_thread),
    .wr_cnt        (wr_cnt),
    .disp_room     (disp_room),
    .thread_en     (thread_en),
    .read_thread   (read_thread),
    .read_cnt      (read_cnt),
    .occ0          (occ0),
    .occ1          (occ1)
  );

  typedef struct {
    bit       we;
    bit       wt;
    int       wc;
    int       room;
    bit [1:0] en;
    int       rt;
    int       rc;
    int       o0;
    int       o1;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_rc();
    int r;
    if (!m_run || !thread_en[m_cur]) return 0;
    r = m_occ[m_cur];
    if (r > 2) r = 2;
    if (r > int'(disp_room)) r = int'(disp_room);
    return r;
  endfunction

  task automatic m_reset();
    m_occ[0] = 0;
    m_occ[1] = 0;
    m_cur    = 0;
    m_run    = 1'b0;
    m_used   = 0;
    m_last   = 1;
  endtask

  task automatic m_step();
    int pop;
    int nocc[2];
    bit rdy[2];
    pop = stall ? 0 : m_rc();
    for (int t = 0; t < 2; t++) begin
      nocc[t] = m_occ[t] + ((wr_en && int'(wr_thread) == t) ? int'(wr_cnt) : 0)
                - ((t == m_cur) ? pop : 0);
      if (except && int'(except_thread) == t) nocc[t] = 0;
      rdy[t] = thread_en[t] && (nocc[t] > 0);
    end
    if (except && int'(except_thread) == m_cur && m_run) begin
      m_run  = 1'b0;
      m_used = 0;
    end else if (!stall) begin
      if (m_run) begin
        if (pop > 0) m_used++;
        if (!rdy[m_cur] || (m_used == QUANTUM && rdy[1-m_cur])) begin
          m_last = m_cur;
          m_used = 0;
          if (rdy[1-m_cur]) m_cur = 1 - m_cur;
          else m_run = 1'b0;
        end else if (m_used == QUANTUM) begin
          m_used = 0;
        end
      end else begin
        if (rdy[0] && rdy[1]) begin
          m_cur = 1 - m_last;
          m_run = 1'b1;
        end else if (rdy[0]) begin
          m_cur = 0;
          m_run = 1'b1;
        end else if (rdy[1]) begin
          m_cur = 1;
          m_run = 1'b1;
        end
      end
    end
    m_occ[0] = nocc[0];
    m_occ[1] = nocc[1];
  endtask

  task automatic set_in(input bit we, input bit wt, input int wc, input int room,
                        input bit [1:0] en, input bit st, input bit ex, input bit et);
    wr_en         = we;
    wr_thread     = wt;
    wr_cnt        = 3'(wc);
    disp_room     = 2'(room);
    thread_en     = en;
    stall         = st;
    except        = ex;
    except_thread = et;
  endtask

  // One clock: compare against the model mid-cycle, advance the model, cross the edge.
  task automatic cycle();
    int pend;
    @(negedge clk);
    chk("read_thread", int'(read_thread), m_cur);
    chk("read_cnt", int'(read_cnt), m_rc());
    chk("occ0", int'(occ0), m_occ[0]);
    chk("occ1", int'(occ1), m_occ[1]);
    pend = m_occ[wr_thread] + int'(wr_cnt)
           - ((!stall && int'(wr_thread) == m_cur) ? m_rc() : 0);
    assert (!(wr_en && pend > 16)) else $error("protocol: write would exceed 16 entries");
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 0, 0, 2'b11, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_read_thread", int'(read_thread), 0);
    chk("rst_read_cnt", int'(read_cnt), 0);
    chk("rst_occ0", int'(occ0), 0);
    chk("rst_occ1", int'(occ1), 0);
    rst = 1'b0;
  endtask

  initial begin
    int wt;
    int lim;
    int occ_before;
    rst = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 2'b11, 1'b0, 1'b0, 1'b0);

    //           we    wt    wc room en     rt rc o0 o1
    vt[0]  = '{1'b1, 1'b0, 3, 2, 2'b11, 0, 0, 0, 0};
    vt[1]  = '{1'b0, 1'b0, 0, 2, 2'b11, 0, 2, 3, 0};
    vt[2]  = '{1'b0, 1'b0, 0, 2, 2'b11, 0, 1, 1, 0};
    vt[3]  = '{1'b1, 1'b1, 4, 2, 2'b11, 0, 0, 0, 0};
    vt[4]  = '{1'b0, 1'b0, 0, 1, 2'b11, 1, 1, 0, 4};
    vt[5]  = '{1'b0, 1'b0, 0, 3, 2'b11, 1, 2, 0, 3};
    vt[6]  = '{1'b1, 1'b1, 2, 2, 2'b11, 1, 1, 0, 1};
    vt[7]  = '{1'b0, 1'b0, 0, 0, 2'b11, 1, 0, 0, 2};
    vt[8]  = '{1'b0, 1'b0, 0, 2, 2'b01, 1, 0, 0, 2};
    vt[9]  = '{1'b0, 1'b0, 0, 2, 2'b11, 1, 0, 0, 2};
    vt[10] = '{1'b0, 1'b0, 0, 2, 2'b11, 1, 2, 0, 2};
    vt[11] = '{1'b1, 1'b0, 1, 2, 2'b11, 1, 0, 0, 0};
    vt[12] = '{1'b0, 1'b0, 0, 2, 2'b11, 0, 1, 1, 0};

    // Directed table
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(vt[i].we, vt[i].wt, vt[i].wc, vt[i].room, vt[i].en, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("tbl%0d_rt", i), int'(read_thread), vt[i].rt);
      chk($sformatf("tbl%0d_rc", i), int'(read_cnt), vt[i].rc);
      chk($sformatf("tbl%0d_occ0", i), int'(occ0), vt[i].o0);
      chk($sformatf("tbl%0d_occ1", i), int'(occ1), vt[i].o1);
      @(posedge clk);
      #1;
    end

    // Round robin with both threads full: 8 cycles each, alternating
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, (i >= 4), 4, 0, 2'b11, 1'b0, 1'b0, 1'b0);
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      set_in(1'b1, ((i / 8) % 2 == 1), 2, 2, 2'b11, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rr_thread", int'(read_thread), (i / 8) % 2);
      chk("rr_cnt", int'(read_cnt), 2);
      cycle();
    end

    // Flush of the running thread with a same-cycle write, then one bubble
    do_reset();
    set_in(1'b1, 1'b1, 4, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 2, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b0, 3, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 4, 0, 2'b11, 1'b0, 1'b1, 1'b1); cycle();
    set_in(1'b0, 1'b0, 0, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    #1;
    chk("flush_occ1", int'(occ1), 0);
    chk("drain_rc", int'(read_cnt), 0);
    cycle();
    #1;
    chk("post_drain_rt", int'(read_thread), 0);
    chk("post_drain_rc", int'(read_cnt), 2);
    cycle();

    // Stall freezes scheduling while writes still land; quantum resumes where it stopped
    do_reset();
    set_in(1'b1, 1'b0, 4, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b0, 1'b0, 0, 2, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    occ_before = int'(occ0);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 1, 2, 2'b11, 1'b1, 1'b0, 1'b0);
      cycle();
    end
    chk("stall_occ0", int'(occ0), occ_before + 5);
    chk("stall_rt", int'(read_thread), 0);
    for (int k = 0; k < 7; k++) begin
      set_in(1'b1, (k == 0), (k == 0) ? 4 : 1, 1, 2'b11, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("quantum_resume_rt", int'(read_thread), (k == 6) ? 1 : 0);
    end

    // Disabled thread 1 with a backlog is never chosen
    do_reset();
    set_in(1'b1, 1'b1, 4, 2, 2'b01, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 4, 2, 2'b01, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b1, 2, 2, 2'b01, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 40; i++) begin
      lim = 16 - m_occ[0];
      if (lim > 4) lim = 4;
      set_in(($urandom_range(2, 0) == 0), 1'b0, $urandom_range(lim, 0),
             $urandom_range(3, 0), 2'b01, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("t1_disabled_rt", int'(read_thread), 0);
    end
    chk("t1_backlog", int'(occ1), 10);

    // Asynchronous reset in the middle of a run
    do_reset();
    set_in(1'b1, 1'b1, 4, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b0, 4, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b1, 1'b0, 3, 0, 2'b11, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b0, 1'b0, 0, 2, 2'b11, 1'b0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_occ0", int'(occ0), 7);
    chk("pre_rst_rt", int'(read_thread), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rt", int'(read_thread), 0);
    chk("async_rst_rc", int'(read_cnt), 0);
    chk("async_rst_occ0", int'(occ0), 0);
    chk("async_rst_occ1", int'(occ1), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wt  = $urandom_range(1, 0);
      lim = 16 - m_occ[wt];
      if (lim > 4) lim = 4;
      set_in(($urandom_range(1, 0) == 1) && (lim > 0), wt[0], $urandom_range(lim, 0),
             $urandom_range(3, 0),
             ($urandom_range(7, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b11,
             ($urandom_range(4, 0) == 0), ($urandom_range(15, 0) == 0),
             ($urandom_range(1, 0) == 1));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
